// File: rtl/mips_muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit owning the HI/LO register pair.
// Latency: MULT/MULTU/DIV/DIVU hold busy for exactly WIDTH cycles, then HI/LO update with a one-cycle done pulse.
// Backpressure: start is ignored while busy=1; the CPU stalls on busy. MTHI/MTLO complete in one edge without busy.
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   start, fncode    request and R-type function code (sampled only when idle)
//   a, b             rs / rt operands
//   busy, done       operation in progress / HI-LO just written by mul/div
//   hi, lo           HI and LO registers
module mips_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       fncode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;

   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [CW-1:0]    count;
   // MUL: acc_r = running high half, sh_r = multiplier shifting out / product low half.
   // DIV: acc_r = partial remainder, sh_r = dividend shifting out / quotient shifting in.
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] sh_r;
   logic [WIDTH-1:0] opnd_r;   // multiplicand or divisor magnitude
   logic [WIDTH-1:0] a_r;      // raw dividend, returned as HI on divide-by-zero
   logic             neg_q_r;  // negate product / quotient at the final edge
   logic             neg_r_r;  // negate remainder at the final edge
   logic             bzero_r;

   // Operand magnitudes for the signed forms
   logic             is_signed;
   logic             sa;
   logic             sb;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   always_comb begin
      is_signed = (fncode == FN_MULT) || (fncode == FN_DIV);
      sa        = is_signed & a[WIDTH-1];
      sb        = is_signed & b[WIDTH-1];
      a_mag     = sa ? -a : a;
      b_mag     = sb ? -b : b;
   end

   // One shift-add multiply step
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_acc_nx;
   logic [WIDTH-1:0] mul_sh_nx;
   logic [2*WIDTH-1:0] mul_prod;
   logic [2*WIDTH-1:0] mul_fix;

   always_comb begin
      mul_sum    = {1'b0, acc_r} + (sh_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
      mul_acc_nx = mul_sum[WIDTH:1];
      mul_sh_nx  = {mul_sum[0], sh_r[WIDTH-1:1]};
      mul_prod   = {mul_acc_nx, mul_sh_nx};
      mul_fix    = neg_q_r ? -mul_prod : mul_prod;
   end

   // One restoring divide step. The partial remainder is always below the
   // divisor, so the trial difference fits in WIDTH+1 bits and its top bit
   // is a clean borrow flag.
   logic [WIDTH:0]   div_trial;
   logic             div_ok;
   logic [WIDTH-1:0] div_acc_nx;
   logic [WIDTH-1:0] div_sh_nx;
   logic [WIDTH-1:0] div_q;
   logic [WIDTH-1:0] div_r;

   always_comb begin
      div_trial  = {acc_r, sh_r[WIDTH-1]} - {1'b0, opnd_r};
      div_ok     = ~div_trial[WIDTH];
      div_acc_nx = div_ok ? div_trial[WIDTH-1:0] : {acc_r[WIDTH-2:0], sh_r[WIDTH-1]};
      div_sh_nx  = {sh_r[WIDTH-2:0], div_ok};
      div_q      = neg_q_r ? -div_sh_nx : div_sh_nx;
      div_r      = neg_r_r ? -div_acc_nx : div_acc_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         count   <= '0;
         acc_r   <= '0;
         sh_r    <= '0;
         opnd_r  <= '0;
         a_r     <= '0;
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         bzero_r <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  case (fncode)
                     FN_MULT, FN_MULTU: begin
                        state   <= S_MUL;
                        busy    <= 1'b1;
                        count   <= '0;
                        acc_r   <= '0;
                        sh_r    <= b_mag;
                        opnd_r  <= a_mag;
                        a_r     <= a;
                        neg_q_r <= sa ^ sb;
                        neg_r_r <= 1'b0;
                        bzero_r <= 1'b0;
                     end
                     FN_DIV, FN_DIVU: begin
                        state   <= S_DIV;
                        busy    <= 1'b1;
                        count   <= '0;
                        acc_r   <= '0;
                        sh_r    <= a_mag;
                        opnd_r  <= b_mag;
                        a_r     <= a;
                        neg_q_r <= sa ^ sb;
                        neg_r_r <= sa;
                        bzero_r <= (b == '0);
                     end
                     FN_MTHI: hi <= a;
                     FN_MTLO: lo <= a;
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               acc_r <= mul_acc_nx;
               sh_r  <= mul_sh_nx;
               count <= count + 1'b1;
               if (count == LAST) begin
                  // Last bit and sign fix-up folded into this edge
                  {hi, lo} <= mul_fix;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  count    <= '0;
                  state    <= S_IDLE;
               end
            end
            S_DIV: begin
               acc_r <= div_acc_nx;
               sh_r  <= div_sh_nx;
               count <= count + 1'b1;
               if (count == LAST) begin
                  if (bzero_r) begin
                     lo <= '1;
                     hi <= a_r;
                  end else begin
                     lo <= div_q;
                     hi <= div_r;
                  end
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  count <= '0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed cases with literal
// results plus randomized traffic, all checked every cycle against a
// cycle-level behavioural model of HI/LO, busy and done.
module tb_mips_muldiv_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [5:0]    fncode;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   bit            m_busy;
   bit            m_done;
   int            m_left;
   logic [31:0]   m_hi, m_lo, p_hi, p_lo;

   always #5 clk = ~clk;

   mips_muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .fncode(fncode),
      .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
   endfunction

   // Result of an accepted op appears exactly W edges after acceptance.
   task automatic model_step();
      longint      sp, sa, sb;
      logic [63:0] up;
      if (reset) begin
         model_reset();
         return;
      end
      m_done = 1'b0;
      if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_hi   = p_hi;
            m_lo   = p_lo;
         end
      end else if (start) begin
         case (fncode)
            6'h18: begin
               sp = longint'($signed(a)) * longint'($signed(b));
               {p_hi, p_lo} = sp;
               m_busy = 1'b1; m_left = W;
            end
            6'h19: begin
               up = {32'b0, a} * {32'b0, b};
               {p_hi, p_lo} = up;
               m_busy = 1'b1; m_left = W;
            end
            6'h1A: begin
               if (b == 0) begin
                  p_lo = 32'hFFFF_FFFF; p_hi = a;
               end else begin
                  sa = longint'($signed(a));
                  sb = longint'($signed(b));
                  p_lo = 32'(sa / sb);
                  p_hi = 32'(sa % sb);
               end
               m_busy = 1'b1; m_left = W;
            end
            6'h1B: begin
               if (b == 0) begin
                  p_lo = 32'hFFFF_FFFF; p_hi = a;
               end else begin
                  p_lo = a / b;
                  p_hi = a % b;
               end
               m_busy = 1'b1; m_left = W;
            end
            6'h11: m_hi = a;
            6'h13: m_lo = a;
            default: ;
         endcase
      end
   endtask

   task automatic compare();
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("hi",   64'(hi),   64'(m_hi));
      chk("lo",   64'(lo),   64'(m_lo));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   // Issue one op, then run until busy drops (bounded); returns busy cycle count.
   task automatic do_op(input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y,
                        output int nbusy);
      fncode = fn; a = x; b = y; start = 1'b1;
      cycle();
      start = 1'b0;
      nbusy = 0;
      for (int i = 0; i < 40 && busy; i++) begin
         nbusy++;
         // operands wiggle while busy; they must not be re-sampled
         a = $urandom; b = $urandom; fncode = 6'($urandom);
         cycle();
      end
      chk("op_timeout", 64'(busy), 64'(0));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         4:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          n;
      bit          saw_done;
      logic [31:0] lo_save;
      logic [5:0]  fns [10];
      fns = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h10, 6'h12, 6'h00, 6'h2A};

      reset = 1'b1; start = 1'b0; fncode = '0; a = '0; b = '0;
      model_reset();
      cycle();
      cycle();
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_hi",   64'(hi),   64'(0));
      chk("reset_lo",   64'(lo),   64'(0));
      reset = 1'b0;
      cycle();

      // Directed arithmetic cases with hand-computed results
      do_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
      chk("multu_max_busy", 64'(n), 64'(32));
      chk("multu_max_done", 64'(done), 64'(1));
      chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      do_op(6'h18, 32'hFFFF_FFFD, 32'd7, n);
      chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      do_op(6'h19, 32'hFFFF_FFFD, 32'd7, n);
      chk("multu_neg", {hi, lo}, 64'h0000_0006_FFFF_FFEB);
      do_op(6'h1A, 32'hFFFF_FFF9, 32'd2, n);
      chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op(6'h1A, 32'd7, 32'hFFFF_FFFE, n);
      chk("div_negdivisor", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
      do_op(6'h1B, 32'd100, 32'd7, n);
      chk("divu", {hi, lo}, 64'h0000_0002_0000_000E);
      do_op(6'h1B, 32'hDEAD_BEEF, 32'd0, n);
      chk("divu_zero_busy", 64'(n), 64'(32));
      chk("divu_zero", {hi, lo}, 64'hDEAD_BEEF_FFFF_FFFF);
      do_op(6'h1A, 32'hDEAD_BEEF, 32'd0, n);
      chk("div_zero", {hi, lo}, 64'hDEAD_BEEF_FFFF_FFFF);
      do_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, n);
      chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);

      // Start while busy is ignored; start in the done cycle is accepted
      fncode = 6'h19; a = 32'd2; b = 32'd3; start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      fncode = 6'h1B; a = 32'd9; b = 32'd3; start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 40 && !done; i++) cycle();
      chk("overlap_done", 64'(done), 64'(1));
      chk("overlap_result", {hi, lo}, 64'h0000_0000_0000_0006);
      fncode = 6'h1B; a = 32'd9; b = 32'd3; start = 1'b1;
      cycle();
      start = 1'b0;
      chk("donecycle_accept", 64'(busy), 64'(1));
      for (int i = 0; i < 40 && busy; i++) cycle();
      chk("donecycle_result", {hi, lo}, 64'h0000_0000_0000_0003);

      // MTHI / MFHI
      lo_save = lo;
      fncode = 6'h11; a = 32'h1234_5678; start = 1'b1;
      cycle();
      start = 1'b0;
      chk("mthi_hi", 64'(hi), 64'h1234_5678);
      chk("mthi_lo", 64'(lo), 64'(lo_save));
      chk("mthi_busy", 64'(busy), 64'(0));
      chk("mthi_done", 64'(done), 64'(0));
      fncode = 6'h10; a = 32'hCAFE_F00D; start = 1'b1;
      cycle();
      start = 1'b0;
      chk("mfhi_noop", {hi, lo}, {32'h1234_5678, lo_save});
      fncode = 6'h13; a = 32'h0BAD_F00D; start = 1'b1;
      cycle();
      start = 1'b0;
      chk("mtlo_lo", 64'(lo), 64'h0BAD_F00D);

      // Reset in the middle of a multiply
      fncode = 6'h18; a = 32'd1234; b = 32'd5678; start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 9; i++) cycle();
      reset = 1'b1;
      #1;
      chk("midreset_busy", 64'(busy), 64'(0));
      chk("midreset_hilo", {hi, lo}, 64'h0);
      model_reset();
      cycle();
      reset = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (done) saw_done = 1'b1;
      end
      chk("midreset_no_done", 64'(saw_done), 64'(0));

      // Randomized traffic, including start requests while busy
      for (int i = 0; i < 2500; i++) begin
         start  = ($urandom_range(0, 2) == 0);
         fncode = fns[$urandom_range(0, 9)];
         a      = pick();
         b      = pick();
         cycle();
      end
      start = 1'b0;
      for (int i = 0; i < 40; i++) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
